// File: rtl/jtag_bridge_pkg.sv
// Shared definitions for the JTAG-to-bus bridge: opcodes, FSM states and
// the layout of the STATUS word returned to the debugger.
package jtag_bridge_pkg;

    // Opcodes carried in the TAP user-op register
    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_SET_ADDR = 8'h01;
    localparam logic [7:0] OP_WRITE    = 8'h02;
    localparam logic [7:0] OP_READ     = 8'h03;
    localparam logic [7:0] OP_STATUS   = 8'h04;

    // Bus wait timer width
    localparam int TIMER_W = 8;

    // STATUS word bit positions (bit 0 always reads zero)
    localparam int STAT_ERR_BIT     = 1;
    localparam int STAT_TIMEOUT_BIT = 2;
    localparam int STAT_OVERRUN_BIT = 3;

    // Command-processing FSM states in the clk domain
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } bridge_state_e;

    // Low nibble of the STATUS word built from the three sticky flags
    function automatic logic [3:0] status_nibble(input logic overrun,
                                                 input logic timeout,
                                                 input logic err);
        logic [3:0] nib;
        nib                   = 4'd0;
        nib[STAT_ERR_BIT]     = err;
        nib[STAT_TIMEOUT_BIT] = timeout;
        nib[STAT_OVERRUN_BIT] = overrun;
        return nib;
    endfunction

endpackage

// File: rtl/jtag_sync2.sv
// Two-flop synchronizer for a single level signal crossing into clk.
module jtag_sync2 (
    input  logic clk,
    input  logic trst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of an asynchronous level, cleared by trst
    always_ff @(posedge clk or negedge trst) begin
        if (!trst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/jtag_bus_bridge.sv
// JTAG user-register to single-beat memory bus bridge. Commands are latched
// in the tck domain, handed to the clk domain with a toggle/ack handshake,
// and executed by a small FSM that drives a req/ack bus.
module jtag_bus_bridge
    import jtag_bridge_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int OP_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              trst,
    input  logic              tck,
    input  logic              clk,
    input  logic [OP_W-1:0]   user_op,
    input  logic              user_op_ready,
    input  logic [DATA_W-1:0] user_data_out,
    output logic [DATA_W-1:0] user_data_in,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_err
);

    // ---------------- tck domain ----------------
    logic [OP_W-1:0]   op_hold_r;
    logic [DATA_W-1:0] data_hold_r;
    logic              req_tog_r;
    logic              overrun_tck_r;
    logic              ack_tog_sync_s;
    logic              outstanding_s;

    // ---------------- clk domain ----------------
    bridge_state_e      state_r, state_nxt_s;
    logic               req_sync_s;
    logic               req_seen_r;
    logic               cmd_s;
    logic               overrun_sync_s;
    logic [ADDR_W-1:0]  addr_r, addr_nxt_s;
    logic [DATA_W-1:0]  rdata_r, rdata_nxt_s;
    logic               err_flag_r, err_nxt_s;
    logic               timeout_flag_r, timeout_nxt_s;
    logic               ack_tog_r, ack_tog_nxt_s;
    logic [TIMER_W-1:0] timer_r, timer_nxt_s;
    logic               bus_req_r, bus_req_nxt_s;
    logic               bus_we_r, bus_we_nxt_s;
    logic [ADDR_W-1:0]  bus_addr_r, bus_addr_nxt_s;
    logic [DATA_W-1:0]  bus_wdata_r, bus_wdata_nxt_s;

    // A command is in flight until its ack toggle has come back to tck
    assign outstanding_s = req_tog_r ^ ack_tog_sync_s;

    // Accept a new command when idle, otherwise drop it and flag the overrun
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            op_hold_r     <= '0;
            data_hold_r   <= '0;
            req_tog_r     <= 1'b0;
            overrun_tck_r <= 1'b0;
        end else if (user_op_ready) begin
            if (!outstanding_s) begin
                op_hold_r   <= user_op;
                data_hold_r <= user_data_out;
                req_tog_r   <= ~req_tog_r;
            end else begin
                overrun_tck_r <= 1'b1;
            end
        end else begin
            overrun_tck_r <= overrun_tck_r;
        end
    end

    jtag_sync2 u_ack_sync (
        .clk  (tck),
        .trst (trst),
        .d    (ack_tog_r),
        .q    (ack_tog_sync_s)
    );

    jtag_sync2 u_req_sync (
        .clk  (clk),
        .trst (trst),
        .d    (req_tog_r),
        .q    (req_sync_s)
    );

    jtag_sync2 u_ovr_sync (
        .clk  (clk),
        .trst (trst),
        .d    (overrun_tck_r),
        .q    (overrun_sync_s)
    );

    // Remember the last synchronized request level for edge detection
    always_ff @(posedge clk or negedge trst) begin
        if (!trst) begin
            req_seen_r <= 1'b0;
        end else begin
            req_seen_r <= req_sync_s;
        end
    end

    // Any change of the synchronized toggle is one new command. The hold
    // registers are read directly: they only change while nothing is
    // outstanding, so they are quiet whenever this pulse fires.
    assign cmd_s = req_sync_s ^ req_seen_r;

    // FSM state register
    always_ff @(posedge clk or negedge trst) begin
        if (!trst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath decisions for command execution
    always_comb begin
        state_nxt_s     = state_r;
        addr_nxt_s      = addr_r;
        rdata_nxt_s     = rdata_r;
        err_nxt_s       = err_flag_r;
        timeout_nxt_s   = timeout_flag_r;
        ack_tog_nxt_s   = ack_tog_r;
        timer_nxt_s     = timer_r;
        bus_req_nxt_s   = bus_req_r;
        bus_we_nxt_s    = bus_we_r;
        bus_addr_nxt_s  = bus_addr_r;
        bus_wdata_nxt_s = bus_wdata_r;
        case (state_r)
            IDLE: begin
                if (cmd_s) begin
                    if (op_hold_r == OP_W'(OP_SET_ADDR)) begin
                        addr_nxt_s  = data_hold_r[ADDR_W-1:0];
                        state_nxt_s = DONE;
                    end else if (op_hold_r == OP_W'(OP_STATUS)) begin
                        // Read-then-clear of the sticky bus flags
                        rdata_nxt_s   = {{(DATA_W-4){1'b0}},
                                         status_nibble(overrun_sync_s, timeout_flag_r, err_flag_r)};
                        err_nxt_s     = 1'b0;
                        timeout_nxt_s = 1'b0;
                        state_nxt_s   = DONE;
                    end else if ((op_hold_r == OP_W'(OP_WRITE)) ||
                                 (op_hold_r == OP_W'(OP_READ))) begin
                        bus_req_nxt_s   = 1'b1;
                        bus_we_nxt_s    = (op_hold_r == OP_W'(OP_WRITE));
                        bus_addr_nxt_s  = addr_r;
                        bus_wdata_nxt_s = data_hold_r;
                        timer_nxt_s     = '0;
                        state_nxt_s     = WAIT;
                    end else begin
                        // NOP and unknown opcodes still complete the handshake
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (bus_ack) begin
                    // An ack on the timeout cycle still completes normally
                    if (!bus_we_r) begin
                        rdata_nxt_s = bus_rdata;
                    end else begin
                        rdata_nxt_s = rdata_r;
                    end
                    err_nxt_s     = err_flag_r | bus_err;
                    bus_req_nxt_s = 1'b0;
                    addr_nxt_s    = addr_r + ADDR_W'(4);
                    state_nxt_s   = DONE;
                end else if (timer_r == TIMER_W'(TIMEOUT)) begin
                    bus_req_nxt_s = 1'b0;
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = DONE;
                end else begin
                    timer_nxt_s = timer_r + TIMER_W'(1);
                end
            end
            DONE: begin
                ack_tog_nxt_s = ~ack_tog_r;
                state_nxt_s   = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Datapath, flag and bus output registers
    always_ff @(posedge clk or negedge trst) begin
        if (!trst) begin
            addr_r         <= '0;
            rdata_r        <= '0;
            err_flag_r     <= 1'b0;
            timeout_flag_r <= 1'b0;
            ack_tog_r      <= 1'b0;
            timer_r        <= '0;
            bus_req_r      <= 1'b0;
            bus_we_r       <= 1'b0;
            bus_addr_r     <= '0;
            bus_wdata_r    <= '0;
        end else begin
            addr_r         <= addr_nxt_s;
            rdata_r        <= rdata_nxt_s;
            err_flag_r     <= err_nxt_s;
            timeout_flag_r <= timeout_nxt_s;
            ack_tog_r      <= ack_tog_nxt_s;
            timer_r        <= timer_nxt_s;
            bus_req_r      <= bus_req_nxt_s;
            bus_we_r       <= bus_we_nxt_s;
            bus_addr_r     <= bus_addr_nxt_s;
            bus_wdata_r    <= bus_wdata_nxt_s;
        end
    end

    assign user_data_in = rdata_r;
    assign bus_req      = bus_req_r;
    assign bus_we       = bus_we_r;
    assign bus_addr     = bus_addr_r;
    assign bus_wdata    = bus_wdata_r;

endmodule

// File: tb/tb_jtag_bus_bridge.sv
// Directed bench for jtag_bus_bridge with a command-level reference model,
// a bus slave responder and a per-cycle bus output comparator.
`timescale 1ns/1ps
module tb_jtag_bus_bridge;
    import jtag_bridge_pkg::*;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int OP_W    = 8;
    localparam int TIMEOUT = 255;

    logic              trst;
    logic              tck;
    logic              clk;
    logic [OP_W-1:0]   user_op;
    logic              user_op_ready;
    logic [DATA_W-1:0] user_data_out;
    logic [DATA_W-1:0] user_data_in;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_err;

    int errors = 0;
    int checks = 0;
    realtime tck_half = 10.0;

    // Reference model state
    logic [31:0] m_addr, m_rdata;
    bit          m_err, m_to, m_ovr;
    bit          exp_active, exp_we;
    logic [31:0] exp_addr, exp_wdata;

    // Slave behaviour (delay in clk cycles, -1 = never ack)
    int          slv_delay;
    logic [31:0] slv_rdata;
    bit          slv_err;
    bit          force_ack;

    // Transaction observations
    int          req_count = 0;
    int          req_len   = 0;
    logic [31:0] last_addr = 32'd0;

    jtag_bus_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .trst          (trst),
        .tck           (tck),
        .clk           (clk),
        .user_op       (user_op),
        .user_op_ready (user_op_ready),
        .user_data_out (user_data_out),
        .user_data_in  (user_data_in),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata),
        .bus_err       (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tck = 1'b0;
        forever #(tck_half) tck = ~tck;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr = 32'd0; m_rdata = 32'd0;
        m_err = 1'b0; m_to = 1'b0; m_ovr = 1'b0;
        exp_active = 1'b0;
    endtask

    // Bus outputs checked on every clk cycle a request is visible
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_req === 1'b1) begin
                if (!prev) begin
                    req_count++;
                    last_addr = bus_addr;
                    req_len   = 0;
                end
                req_len++;
                chk("req_expected", {31'd0, exp_active}, 32'd1);
                chk("bus_we", {31'd0, bus_we}, {31'd0, exp_we});
                chk("bus_addr", bus_addr, exp_addr);
                chk("bus_wdata", bus_wdata, exp_wdata);
            end
            prev = (bus_req === 1'b1);
        end
    end

    // Slave responder: one-cycle ack after slv_delay cycles of request
    initial begin
        int cnt;
        cnt = 0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (bus_ack) begin
                bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0; cnt = 0;
                chk("req_drop_after_ack", {31'd0, bus_req}, 32'd0);
            end else if (force_ack) begin
                force_ack = 1'b0;
                bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'hBAD0BAD0;
            end else if (bus_req === 1'b1) begin
                cnt++;
                if (cnt == slv_delay) begin
                    bus_ack = 1'b1; bus_rdata = slv_rdata; bus_err = slv_err;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic send(input logic [7:0] op, input logic [31:0] data);
        @(negedge tck);
        user_op = op; user_data_out = data; user_op_ready = 1'b1;
        @(negedge tck);
        user_op_ready = 1'b0;
    endtask

    task automatic wait_bus(input int start);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 800 && !done; n++) begin
            @(negedge clk);
            if (req_count > start && bus_req === 1'b0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL bus_txn_timeout: no completed transaction within 800 clk");
        end
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
        repeat (4) @(negedge tck);
    endtask

    // Issue one command, let it complete, advance the model and compare
    task automatic do_cmd(input logic [7:0] op, input logic [31:0] data);
        int start;
        bit is_bus;
        is_bus = (op == OP_WRITE) || (op == OP_READ);
        start  = req_count;
        if (is_bus) begin
            exp_we = (op == OP_WRITE); exp_addr = m_addr; exp_wdata = data;
            exp_active = 1'b1;
        end
        send(op, data);
        if (is_bus) wait_bus(start);
        settle();
        exp_active = 1'b0;
        case (op)
            OP_SET_ADDR: m_addr = data;
            OP_STATUS: begin
                m_rdata = {28'd0, m_ovr, m_to, m_err, 1'b0};
                m_err = 1'b0; m_to = 1'b0;
            end
            OP_WRITE, OP_READ: begin
                if (slv_delay >= 1 && slv_delay <= TIMEOUT + 1) begin
                    if (op == OP_READ) m_rdata = slv_rdata;
                    if (slv_err) m_err = 1'b1;
                    m_addr = m_addr + 32'd4;
                end else begin
                    m_to = 1'b1;
                end
            end
            default: ;
        endcase
        chk("user_data_in_model", user_data_in, m_rdata);
        if (is_bus) chk("one_txn_per_cmd", req_count, start + 1);
        else        chk("no_txn_for_cmd", req_count, start);
    endtask

    initial begin
        int start;
        bit seen;
        trst = 1'b0; user_op = '0; user_data_out = '0; user_op_ready = 1'b0;
        force_ack = 1'b0; slv_delay = 3; slv_rdata = 32'd0; slv_err = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_user_data_in", user_data_in, 32'd0);
        @(negedge clk); trst = 1'b1;
        repeat (4) @(negedge tck);

        // Write with a 3-cycle slave
        do_cmd(OP_SET_ADDR, 32'h0000_1000);
        do_cmd(OP_WRITE, 32'hDEAD_BEEF);
        chk("wr_addr_lit", last_addr, 32'h0000_1000);
        chk("wr_req_len_lit", req_len, 32'd3);

        // Reads, auto-increment
        do_cmd(OP_SET_ADDR, 32'h0000_2000);
        slv_rdata = 32'h1234_5678;
        do_cmd(OP_READ, 32'd0);
        chk("rd_data_lit", user_data_in, 32'h1234_5678);
        slv_rdata = 32'hCAFE_F00D;
        do_cmd(OP_READ, 32'd0);
        chk("rd_incr_addr_lit", last_addr, 32'h0000_2004);

        // Timeout: TIMEOUT full wait cycles elapse, abort on the next edge
        slv_delay = -1;
        do_cmd(OP_READ, 32'd0);
        chk("timeout_req_len", req_len, TIMEOUT + 1);
        chk("timeout_keeps_rdata_lit", user_data_in, 32'hCAFE_F00D);
        slv_delay = 3;
        do_cmd(OP_STATUS, 32'd0);
        chk("status_timeout_lit", user_data_in, 32'h0000_0004);
        do_cmd(OP_STATUS, 32'd0);
        chk("status_cleared_lit", user_data_in, 32'h0000_0000);

        // Slave error
        slv_err = 1'b1;
        do_cmd(OP_WRITE, 32'h0000_1111);
        slv_err = 1'b0;
        do_cmd(OP_STATUS, 32'd0);
        chk("status_err_lit", user_data_in, 32'h0000_0002);

        // Unknown opcode acts as NOP
        do_cmd(8'h7F, 32'h0000_0055);

        // Overrun: two accepted-edge pulses 1 tck apart with tck 10x clk
        tck_half = 0.5;
        repeat (4) @(negedge tck);
        start = req_count;
        exp_we = 1'b1; exp_addr = m_addr; exp_wdata = 32'hA5A5_A5A5; exp_active = 1'b1;
        @(negedge tck);
        user_op = OP_WRITE; user_data_out = 32'hA5A5_A5A5; user_op_ready = 1'b1;
        @(negedge tck);
        user_data_out = 32'h5A5A_5A5A;
        @(negedge tck);
        user_op_ready = 1'b0;
        wait_bus(start);
        settle();
        exp_active = 1'b0;
        m_addr = m_addr + 32'd4; m_ovr = 1'b1;
        chk("overrun_single_txn", req_count, start + 1);
        tck_half = 10.0;
        repeat (2) @(negedge tck);
        do_cmd(OP_STATUS, 32'd0);
        chk("status_overrun_lit", user_data_in, 32'h0000_0008);
        do_cmd(OP_STATUS, 32'd0);
        chk("status_overrun_sticky_lit", user_data_in, 32'h0000_0008);

        // Reset while waiting on the bus, then a late ack
        slv_delay = -1;
        exp_we = 1'b1; exp_addr = m_addr; exp_wdata = 32'h0000_0077; exp_active = 1'b1;
        send(OP_WRITE, 32'h0000_0077);
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (bus_req === 1'b1) seen = 1'b1;
        end
        chk("rst_test_req_seen", {31'd0, seen}, 32'd1);
        repeat (3) @(negedge clk);
        #2;
        exp_active = 1'b0;
        trst = 1'b0;
        #1;
        chk("rst_mid_wait_req", {31'd0, bus_req}, 32'd0);
        chk("rst_mid_wait_data_in", user_data_in, 32'd0);
        model_reset();
        @(negedge clk); @(negedge clk);
        trst = 1'b1;
        repeat (2) @(negedge clk);
        force_ack = 1'b1;
        slv_delay = 3;
        repeat (10) @(negedge clk);
        settle();
        do_cmd(OP_STATUS, 32'd0);
        chk("status_after_late_ack_lit", user_data_in, 32'h0000_0000);
        do_cmd(OP_WRITE, 32'h0000_0099);
        chk("wr_after_rst_addr_lit", last_addr, 32'h0000_0000);

        // Address wrap
        do_cmd(OP_SET_ADDR, 32'hFFFF_FFFC);
        do_cmd(OP_WRITE, 32'h0000_0001);
        chk("wrap_first_addr_lit", last_addr, 32'hFFFF_FFFC);
        do_cmd(OP_WRITE, 32'h0000_0002);
        chk("wrap_addr_lit", last_addr, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
